// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Brief    : Control-bundle pipeline for a 5-stage MIPS core. Carries the
//            decoder's ex/m/wb bundle through ID/EX, EX/MEM and MEM/WB,
//            unpacks it into per-stage strobes, and generates load-use
//            stalls, flush bubbles and EX-stage forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    // ID-stage bundle from the main decoder
    input  logic [1:0]      id_ex,
    input  logic [2:0]      id_m,
    input  logic [1:0]      id_wb,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            flush,
    // EX stage
    output logic            ex_reg_dst,
    output logic            ex_alu_src,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    // MEM stage
    output logic            mem_branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic [RA_W-1:0] mem_wreg,
    // WB stage
    output logic            wb_mem_to_reg,
    output logic            wb_reg_write,
    output logic [RA_W-1:0] wb_wreg,
    // Front-end hazard control
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush
);

    // Operand-select encodings
    localparam logic [1:0]      C_FWD_RF   = 2'b00;
    localparam logic [1:0]      C_FWD_EXM  = 2'b10;
    localparam logic [1:0]      C_FWD_MWB  = 2'b01;
    localparam logic [RA_W-1:0] C_REG_ZERO = '0;

    // ------------------------------------------------------------------------
    // Pipeline state not directly visible on the ports
    // ------------------------------------------------------------------------
    logic [2:0]      r_ex_m;      // branch, mem_read, mem_write
    logic [1:0]      r_ex_wb;     // mem_to_reg, reg_write
    logic [RA_W-1:0] r_ex_rd;     // only needed to form mem_wreg
    logic [1:0]      r_mem_wb;    // mem_to_reg, reg_write

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_ex_mem_read;
    logic w_load_use;
    logic w_stall;
    logic w_idex_bubble;
    logic w_mem_reg_write;

    assign w_ex_mem_read   = r_ex_m[1];
    assign w_mem_reg_write = r_mem_wb[0];

    // Load in EX whose destination is a source of the instruction in ID.
    // $0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_load_use = id_valid
                      & w_ex_mem_read
                      & (ex_rt != C_REG_ZERO)
                      & ((ex_rt == id_rs) | (ex_rt == id_rt));

    // A redirect squashes the dependent instruction anyway, so it cancels
    // the stall and lets the front end fetch the new target immediately.
    assign w_stall       = w_load_use & ~flush;
    assign w_idex_bubble = flush | ~id_valid | w_stall;

    assign pc_en      = ~w_stall;
    assign ifid_en    = ~w_stall;
    assign ifid_flush = flush;

    // ------------------------------------------------------------------------
    // ID/EX register: load the decoded bundle or insert a bubble
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_reg_dst <= 1'b0;
            ex_alu_src <= 1'b0;
            r_ex_m     <= 3'b000;
            r_ex_wb    <= 2'b00;
            ex_rs      <= C_REG_ZERO;
            ex_rt      <= C_REG_ZERO;
            r_ex_rd    <= C_REG_ZERO;
        end else if (w_idex_bubble) begin
            ex_reg_dst <= 1'b0;
            ex_alu_src <= 1'b0;
            r_ex_m     <= 3'b000;
            r_ex_wb    <= 2'b00;
            ex_rs      <= C_REG_ZERO;
            ex_rt      <= C_REG_ZERO;
            r_ex_rd    <= C_REG_ZERO;
        end else begin
            ex_reg_dst <= id_ex[1];
            ex_alu_src <= id_ex[0];
            r_ex_m     <= id_m;
            r_ex_wb    <= id_wb;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            r_ex_rd    <= id_rd;
        end
    end

    // ------------------------------------------------------------------------
    // EX/MEM register: unpack m, carry wb, resolve the destination register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_branch <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            r_mem_wb   <= 2'b00;
            mem_wreg   <= C_REG_ZERO;
        end else begin
            mem_branch <= r_ex_m[2];
            mem_read   <= r_ex_m[1];
            mem_write  <= r_ex_m[0];
            r_mem_wb   <= r_ex_wb;
            mem_wreg   <= ex_reg_dst ? r_ex_rd : ex_rt;
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB register: unpack wb and carry the destination register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_wreg       <= C_REG_ZERO;
        end else begin
            wb_mem_to_reg <= r_mem_wb[1];
            wb_reg_write  <= r_mem_wb[0];
            wb_wreg       <= mem_wreg;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selection
    // ------------------------------------------------------------------------
    generate
        if (FWD_EN) begin : g_fwd
            logic w_exm_ok;
            logic w_mwb_ok;

            // A stage may forward only if it writes a real (non-$0) register
            assign w_exm_ok = w_mem_reg_write & (mem_wreg != C_REG_ZERO);
            assign w_mwb_ok = wb_reg_write    & (wb_wreg  != C_REG_ZERO);

            // EX/MEM is checked first because it holds the newer result
            always_comb begin
                fwd_a = C_FWD_RF;
                if (w_exm_ok && (mem_wreg == ex_rs)) begin
                    fwd_a = C_FWD_EXM;
                end else if (w_mwb_ok && (wb_wreg == ex_rs)) begin
                    fwd_a = C_FWD_MWB;
                end
            end

            // Same priority for the second operand, matched against rt
            always_comb begin
                fwd_b = C_FWD_RF;
                if (w_exm_ok && (mem_wreg == ex_rt)) begin
                    fwd_b = C_FWD_EXM;
                end else if (w_mwb_ok && (wb_wreg == ex_rt)) begin
                    fwd_b = C_FWD_MWB;
                end
            end
        end else begin : g_no_fwd
            assign fwd_a = C_FWD_RF;
            assign fwd_b = C_FWD_RF;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Directed self-checking bench for ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic [1:0]      id_ex;
    logic [2:0]      id_m;
    logic [1:0]      id_wb;
    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            flush;
    logic            ex_reg_dst;
    logic            ex_alu_src;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            mem_branch;
    logic            mem_read;
    logic            mem_write;
    logic [RA_W-1:0] mem_wreg;
    logic            wb_mem_to_reg;
    logic            wb_reg_write;
    logic [RA_W-1:0] wb_wreg;
    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;

    int errors = 0;
    int checks = 0;

    ctrl_pipe #(.RA_W(RA_W), .FWD_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_ex         (id_ex),
        .id_m          (id_m),
        .id_wb         (id_wb),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .flush         (flush),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_branch    (mem_branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_wreg      (mem_wreg),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_wreg       (wb_wreg),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an ID-stage instruction and let the combinational outputs settle
    task automatic drive(input logic [1:0] ex, input logic [2:0] m, input logic [1:0] wb,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl);
        id_ex    = ex;
        id_m     = m;
        id_wb    = wb;
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        flush    = fl;
        #1;
    endtask

    task automatic nop();
        drive(2'b00, 3'b000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- Reset: a valid bundle is presented but must not load
        rst_n = 1'b0;
        drive(2'b11, 3'b111, 2'b11, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0);
        tick();
        tick();
        chk("rst_ex_reg_dst", {7'd0, ex_reg_dst}, 8'd0);
        chk("rst_ex_rs",      {3'd0, ex_rs},      8'd0);
        chk("rst_mem_read",   {7'd0, mem_read},   8'd0);
        chk("rst_mem_wreg",   {3'd0, mem_wreg},   8'd0);
        chk("rst_wb_regwr",   {7'd0, wb_reg_write}, 8'd0);
        chk("rst_fwd_a",      {6'd0, fwd_a},      8'd0);
        chk("rst_pc_en",      {7'd0, pc_en},      8'd1);
        chk("rst_ifid_en",    {7'd0, ifid_en},    8'd1);
        chk("rst_ifid_flush", {7'd0, ifid_flush}, 8'd0);

        // ---------------- Single add through the pipe: rs=1 rt=2 rd=5
        rst_n = 1'b1;
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        chk("add_ex_reg_dst", {7'd0, ex_reg_dst}, 8'd1);
        chk("add_ex_alu_src", {7'd0, ex_alu_src}, 8'd0);
        chk("add_ex_rs",      {3'd0, ex_rs},      8'd1);
        chk("add_ex_rt",      {3'd0, ex_rt},      8'd2);
        nop();
        tick();
        chk("add_mem_wreg",   {3'd0, mem_wreg},   8'd5);
        chk("add_mem_read",   {7'd0, mem_read},   8'd0);
        chk("add_ex_bubble",  {7'd0, ex_reg_dst}, 8'd0);
        tick();
        chk("add_wb_regwr",   {7'd0, wb_reg_write},  8'd1);
        chk("add_wb_wreg",    {3'd0, wb_wreg},       8'd5);
        chk("add_wb_m2r",     {7'd0, wb_mem_to_reg}, 8'd0);
        tick();

        // ---------------- Load-use: lw rs=9 rt=8, then add rs=8 rt=4 rd=10
        drive(2'b01, 3'b010, 2'b11, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
        tick();
        chk("lw_ex_alu_src", {7'd0, ex_alu_src}, 8'd1);
        chk("lw_ex_rt",      {3'd0, ex_rt},      8'd8);
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd8, 5'd4, 5'd10, 1'b0);
        chk("lu_pc_en",   {7'd0, pc_en},   8'd0);
        chk("lu_ifid_en", {7'd0, ifid_en}, 8'd0);
        tick();
        chk("lu_bubble_dst", {7'd0, ex_reg_dst}, 8'd0);
        chk("lu_bubble_rs",  {3'd0, ex_rs},      8'd0);
        chk("lu_mem_read",   {7'd0, mem_read},   8'd1);
        chk("lu_mem_wreg",   {3'd0, mem_wreg},   8'd8);
        chk("lu_pc_en_rel",  {7'd0, pc_en},      8'd1);
        tick();
        chk("lu_add_ex_rs",  {3'd0, ex_rs},         8'd8);
        chk("lu_wb_m2r",     {7'd0, wb_mem_to_reg}, 8'd1);
        chk("lu_fwd_a",      {6'd0, fwd_a},         8'd1);
        chk("lu_fwd_b",      {6'd0, fwd_b},         8'd0);
        nop();
        tick();
        tick();
        tick();

        // ---------------- Double forward on $3, then WB-only forward on rt
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd3, 5'd3, 5'd6, 1'b0);
        tick();
        chk("dbl_fwd_a", {6'd0, fwd_a}, 8'd2);
        chk("dbl_fwd_b", {6'd0, fwd_b}, 8'd2);
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd0, 5'd3, 5'd7, 1'b0);
        tick();
        chk("wbonly_fwd_a", {6'd0, fwd_a}, 8'd0);
        chk("wbonly_fwd_b", {6'd0, fwd_b}, 8'd1);
        nop();
        tick();
        tick();
        tick();

        // ---------------- $0 guard: add rd=0, then reader of rs=0/rt=0
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0);
        tick();
        chk("z_fwd_a", {6'd0, fwd_a}, 8'd0);
        chk("z_fwd_b", {6'd0, fwd_b}, 8'd0);
        // lw with rt=0 followed by a use of $0 must not stall
        drive(2'b01, 3'b010, 2'b11, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd0, 5'd5, 5'd11, 1'b0);
        chk("z_pc_en",   {7'd0, pc_en},   8'd1);
        chk("z_ifid_en", {7'd0, ifid_en}, 8'd1);
        nop();
        tick();
        tick();
        tick();

        // ---------------- Flush over stall
        drive(2'b01, 3'b010, 2'b11, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd8, 5'd4, 5'd10, 1'b1);
        chk("fl_pc_en",      {7'd0, pc_en},      8'd1);
        chk("fl_ifid_en",    {7'd0, ifid_en},    8'd1);
        chk("fl_ifid_flush", {7'd0, ifid_flush}, 8'd1);
        tick();
        chk("fl_bubble_dst", {7'd0, ex_reg_dst}, 8'd0);
        chk("fl_bubble_rs",  {3'd0, ex_rs},      8'd0);
        // Invalid ID slot: hazard pattern present but no stall, bubble loaded
        drive(2'b01, 3'b010, 2'b11, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b0, 5'd8, 5'd4, 5'd10, 1'b0);
        chk("inv_pc_en", {7'd0, pc_en}, 8'd1);
        tick();
        chk("inv_bubble_rs", {3'd0, ex_rs}, 8'd0);
        nop();
        tick();
        tick();
        tick();

        // ---------------- Mid-stream reset with three adds in flight
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd12, 1'b0);
        tick();
        drive(2'b10, 3'b000, 2'b01, 1'b1, 5'd1, 5'd2, 5'd13, 1'b0);
        tick();
        chk("ms_pre_wb_wreg", {3'd0, wb_wreg}, 8'd11);
        rst_n = 1'b0;
        nop();
        tick();
        chk("ms_ex_reg_dst", {7'd0, ex_reg_dst},   8'd0);
        chk("ms_mem_wreg",   {3'd0, mem_wreg},     8'd0);
        chk("ms_wb_regwr",   {7'd0, wb_reg_write}, 8'd0);
        chk("ms_wb_wreg",    {3'd0, wb_wreg},      8'd0);
        chk("ms_pc_en",      {7'd0, pc_en},        8'd1);
        rst_n = 1'b1;
        tick();
        chk("ms_post1_wb", {7'd0, wb_reg_write}, 8'd0);
        tick();
        chk("ms_post2_wb", {7'd0, wb_reg_write}, 8'd0);
        chk("ms_post2_wreg", {3'd0, wb_wreg}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
